wb_merge_queue: RTL and testbench

- Writeback buffer sitting directly upstream of the 8x16 register file.
- Accepts results from two producers, ALU and load/memory, over valid/ready channels and queues them in program-order FIFO.
- Drives the register file's two write ports, retiring up to 2 results per cycle.
- Publishes a pending-write mask so the issue stage can detect RAW hazards.

---
 rtl/wb_merge_queue.sv | 142 ++++++++++++++
 tb/tb_wb_merge_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_merge_queue.sv
// Writeback merge queue: collects ALU and load results into a program-order FIFO
// and retires up to two per cycle onto the register file's two write ports.
module wb_merge_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     wb_hold,
  output logic [1:0]               write_en,
  output logic [ADDR_W-1:0]        reg_write_addr_0,
  output logic [ADDR_W-1:0]        reg_write_addr_1,
  output logic [DATA_W-1:0]        data_in_0,
  output logic [DATA_W-1:0]        data_in_1,
  output logic [7:0]               pending_mask,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_wr_ptr, rd_ptr_1, idx;
  logic [CW-1:0]     count_q, count_d, free;
  logic [1:0]        enq_n, pop_n;
  logic              alu_fire, mem_fire;

  logic [1:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;

  // Ready depends only on registered occupancy, so draining never feeds back into ready.
  always_comb begin
    free      = CW'(DEPTH) - count_q;
    alu_ready = rst & (free >= CW'(1));
    mem_ready = rst & ((free >= CW'(2)) | ((free >= CW'(1)) & ~alu_valid));
    alu_fire  = alu_valid & alu_ready;
    mem_fire  = mem_valid & mem_ready;
    enq_n     = 2'(alu_fire) + 2'(mem_fire);
    // ALU entry is older than a same-cycle load entry.
    mem_wr_ptr = alu_fire ? wr_ptr_q + PW'(1) : wr_ptr_q;
    wr_ptr_d   = wr_ptr_q + PW'(enq_n);
  end

  // Pop count, output-stage next state and merge of same-register pairs.
  always_comb begin
    if (wb_hold) begin
      pop_n = 2'd0;
    end else if (count_q >= CW'(2)) begin
      pop_n = 2'd2;
    end else begin
      pop_n = 2'(count_q);
    end
    rd_ptr_1 = rd_ptr_q + PW'(1);
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    count_d  = count_q + CW'(enq_n) - CW'(pop_n);
    we_d     = 2'b00;
    addr0_d  = addr0_q;
    addr1_d  = addr1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    if (pop_n != 2'd0) begin
      addr0_d = addr_mem[rd_ptr_q];
      data0_d = data_mem[rd_ptr_q];
      we_d    = 2'b01;
    end
    if (pop_n == 2'd2) begin
      addr1_d = addr_mem[rd_ptr_1];
      data1_d = data_mem[rd_ptr_1];
      // Same destination: only the newer value is written.
      we_d    = (addr_mem[rd_ptr_q] == addr_mem[rd_ptr_1]) ? 2'b10 : 2'b11;
    end
  end

  // Pointer, occupancy and output-stage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= '0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      addr0_q  <= addr0_d;
      addr1_q  <= addr1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
    end
  end

  // FIFO storage; validity is tracked by pointers and count, so no reset needed.
  always_ff @(posedge clk) begin
    if (alu_fire) begin
      addr_mem[wr_ptr_q] <= alu_addr;
      data_mem[wr_ptr_q] <= alu_data;
    end
    if (mem_fire) begin
      addr_mem[mem_wr_ptr] <= mem_addr;
      data_mem[mem_wr_ptr] <= mem_data;
    end
  end

  // Pending-write mask from valid FIFO entries plus enabled output ports.
  always_comb begin
    pending_mask = 8'h00;
    idx          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        pending_mask[addr_mem[idx]] = 1'b1;
      end
    end
    if (we_q[0]) pending_mask[addr0_q] = 1'b1;
    if (we_q[1]) pending_mask[addr1_q] = 1'b1;
  end

  assign write_en         = we_q;
  assign reg_write_addr_0 = addr0_q;
  assign reg_write_addr_1 = addr1_q;
  assign data_in_0        = data0_q;
  assign data_in_1        = data1_q;
  assign count            = count_q;

endmodule

// File: tb/tb_wb_merge_queue.sv
// Self-checking bench for wb_merge_queue: per-cycle vector table plus a write scoreboard.
module tb_wb_merge_queue;

  logic        clk, rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready, wb_hold;
  logic [2:0]  alu_addr, mem_addr, reg_write_addr_0, reg_write_addr_1;
  logic [15:0] alu_data, mem_data, data_in_0, data_in_1;
  logic [1:0]  write_en;
  logic [7:0]  pending_mask;
  logic [2:0]  count;

  wb_merge_queue #(.DEPTH(4), .ADDR_W(3), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_hold(wb_hold), .write_en(write_en),
    .reg_write_addr_0(reg_write_addr_0), .reg_write_addr_1(reg_write_addr_1),
    .data_in_0(data_in_0), .data_in_1(data_in_1),
    .pending_mask(pending_mask), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } ent_t;

  typedef struct packed {
    logic        av;
    logic [2:0]  aa;
    logic [15:0] ad;
    logic        mv;
    logic [2:0]  ma;
    logic [15:0] md;
    logic        hold;
    logic        ear;
    logic        emr;
    logic [2:0]  ecnt;
    logic [1:0]  ewe;
    logic [7:0]  emask;
  } vec_t;

  ent_t        sb[$];
  logic [15:0] rf[8];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One cycle: drive inputs, sample ready, record handshakes, then step past the edge.
  task automatic step(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                      input logic mv, input logic [2:0] ma, input logic [15:0] md,
                      input logic hold, output logic ar, output logic mr);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    wb_hold   = hold;
    #1;
    ar = alu_ready;
    mr = mem_ready;
    if (av && ar) sb.push_back('{a: aa, d: ad});
    if (mv && mr) sb.push_back('{a: ma, d: md});
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  // Retirement monitor: compares port traffic against the scoreboard and models the regfile.
  always @(negedge clk) begin
    ent_t e0, e1;
    if (rst && write_en != 2'b00) begin
      if (write_en[1]) begin
        if (sb.size() < 2) begin
          chk("sb_underflow2", sb.size(), 2);
        end else begin
          e0 = sb.pop_front();
          e1 = sb.pop_front();
          chk("pair_we", write_en, (e0.a == e1.a) ? 2'b10 : 2'b11);
          chk("p0_addr", reg_write_addr_0, e0.a);
          chk("p1_addr", reg_write_addr_1, e1.a);
          chk("p1_data", data_in_1, e1.d);
          if (write_en[0]) chk("p0_data", data_in_0, e0.d);
        end
      end else begin
        if (sb.size() < 1) begin
          chk("sb_underflow1", sb.size(), 1);
        end else begin
          e0 = sb.pop_front();
          chk("p0_addr", reg_write_addr_0, e0.a);
          chk("p0_data", data_in_0, e0.d);
        end
      end
      if (write_en[0]) rf[reg_write_addr_0] = data_in_0;
      if (write_en[1]) rf[reg_write_addr_1] = data_in_1;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  vec_t tbl[23];
  logic ar, mr;

  initial begin
    tbl[0]  = '{1'b1,3'd2,16'hAAAA,1'b1,3'd5,16'h5555,1'b0, 1'b1,1'b1,3'd2,2'b00,8'h24};
    tbl[1]  = '{1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0, 1'b1,1'b1,3'd0,2'b11,8'h24};
    tbl[2]  = '{1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0, 1'b1,1'b1,3'd0,2'b00,8'h00};
    tbl[3]  = '{1'b1,3'd4,16'h1111,1'b1,3'd4,16'h2222,1'b0, 1'b1,1'b1,3'd2,2'b00,8'h10};
    tbl[4]  = '{1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0, 1'b1,1'b1,3'd0,2'b10,8'h10};
    tbl[5]  = '{1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0, 1'b1,1'b1,3'd0,2'b00,8'h00};
    tbl[6]  = '{1'b1,3'd1,16'h0101,1'b0,3'd0,16'h0000,1'b1, 1'b1,1'b1,3'd1,2'b00,8'h02};
    tbl[7]  = '{1'b1,3'd2,16'h0202,1'b0,3'd0,16'h0000,1'b1, 1'b1,1'b1,3'd2,2'b00,8'h06};
    tbl[8]  = '{1'b1,3'd3,16'h0303,1'b0,3'd0,16'h0000,1'b1, 1'b1,1'b1,3'd3,2'b00,8'h0E};
    tbl[9]  = '{1'b1,3'd4,16'h0404,1'b0,3'd0,16'h0000,1'b1, 1'b1,1'b0,3'd4,2'b00,8'h1E};
    tbl[10] = '{1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b1, 1'b0,1'b0,3'd4,2'b00,8'h1E};
    tbl[11] = '{1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0, 1'b0,1'b0,3'd2,2'b11,8'h1E};
    tbl[12] = '{1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0, 1'b1,1'b1,3'd0,2'b11,8'h18};
    tbl[13] = '{1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0, 1'b1,1'b1,3'd0,2'b00,8'h00};
    tbl[14] = '{1'b1,3'd5,16'h0505,1'b0,3'd0,16'h0000,1'b1, 1'b1,1'b1,3'd1,2'b00,8'h20};
    tbl[15] = '{1'b1,3'd6,16'h0606,1'b1,3'd7,16'h0707,1'b1, 1'b1,1'b1,3'd3,2'b00,8'hE0};
    tbl[16] = '{1'b1,3'd1,16'h1111,1'b1,3'd2,16'h2222,1'b1, 1'b1,1'b0,3'd4,2'b00,8'hE2};
    tbl[17] = '{1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0, 1'b0,1'b0,3'd2,2'b11,8'hE2};
    tbl[18] = '{1'b0,3'd0,16'h0000,1'b1,3'd3,16'h3333,1'b1, 1'b1,1'b1,3'd3,2'b00,8'h8A};
    tbl[19] = '{1'b0,3'd0,16'h0000,1'b1,3'd2,16'h2222,1'b1, 1'b1,1'b1,3'd4,2'b00,8'h8E};
    tbl[20] = '{1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0, 1'b0,1'b0,3'd2,2'b11,8'h8E};
    tbl[21] = '{1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0, 1'b1,1'b1,3'd0,2'b11,8'h0C};
    tbl[22] = '{1'b0,3'd0,16'h0000,1'b0,3'd0,16'h0000,1'b0, 1'b1,1'b1,3'd0,2'b00,8'h00};

    rst = 1'b0; wb_hold = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    for (int r = 0; r < 8; r++) rf[r] = 16'h0;

    // Power-on reset state.
    #3;
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_count", count, 0);
    chk("rst_mask", pending_mask, 0);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    // Single ALU write latency.
    step(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, 1'b0, ar, mr);
    chk("t2_ready", ar, 1);
    chk("t2_mask_n", pending_mask, 8'h08);
    chk("t2_count_n", count, 1);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, ar, mr);
    chk("t2_we_n1", write_en, 2'b01);
    chk("t2_addr0", reg_write_addr_0, 3);
    chk("t2_data0", data_in_0, 16'h1234);
    chk("t2_mask_n1", pending_mask, 8'h08);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, ar, mr);
    chk("t2_we_n2", write_en, 2'b00);
    chk("t2_mask_n2", pending_mask, 8'h00);

    // Table of per-cycle vectors: pairs, merge, hold/full, near-full arbitration.
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md, tbl[i].hold,
           ar, mr);
      chk($sformatf("v%0d_alu_ready", i), ar, tbl[i].ear);
      chk($sformatf("v%0d_mem_ready", i), mr, tbl[i].emr);
      chk($sformatf("v%0d_count", i), count, tbl[i].ecnt);
      chk($sformatf("v%0d_write_en", i), write_en, tbl[i].ewe);
      chk($sformatf("v%0d_mask", i), pending_mask, tbl[i].emask);
      if (i == 5) chk("merge_rf4", rf[4], 16'h2222);
    end
    chk("sb_empty_mid", sb.size(), 0);

    // Reset while entries are queued and both ports are firing.
    step(1'b1, 3'd1, 16'hC001, 1'b1, 3'd2, 16'hC002, 1'b1, ar, mr);
    step(1'b1, 3'd3, 16'hC003, 1'b0, 3'd0, 16'h0, 1'b1, ar, mr);
    chk("t1_count_pre", count, 3);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, ar, mr);
    chk("t1_we_pre", write_en, 2'b11);
    chk("t1_count_mid", count, 1);
    #1 rst = 1'b0;
    #1;
    chk("t1_we_rst", write_en, 0);
    chk("t1_count_rst", count, 0);
    chk("t1_mask_rst", pending_mask, 0);
    chk("t1_alu_ready_rst", alu_ready, 0);
    chk("t1_mem_ready_rst", mem_ready, 0);
    sb.delete();
    #3 rst = 1'b1;
    #1;
    chk("t1_alu_ready_rel", alu_ready, 1);
    chk("t1_mem_ready_rel", mem_ready, 1);
    @(posedge clk);
    #1;
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, ar, mr);
    chk("t1_we_post", write_en, 0);

    // Bounded wait for any remaining expected writes to retire.
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
